// File: rtl/hpdcache_pkg.sv
// Shared types for the HPDcache write-buffer timer controller:
// entry-state encoding, entry-id and idle-counter types.
package hpdcache_pkg;

  localparam int unsigned WBUF_N_ENTRIES = 16;
  localparam int unsigned WBUF_TIMECNT_WIDTH = 4;
  localparam int unsigned WBUF_ID_WIDTH =
    $clog2(WBUF_N_ENTRIES);

  typedef enum logic [1:0] {
    WBUF_FREE = 2'd0,
    WBUF_OPEN = 2'd1,
    WBUF_PEND = 2'd2,
    WBUF_SENT = 2'd3
  } wbuf_state_e;

  typedef logic [WBUF_ID_WIDTH-1:0] wbuf_id_t;

  typedef logic [WBUF_TIMECNT_WIDTH-1:0] wbuf_timecnt_t;

endpackage

// File: rtl/hpdcache_rr_arbiter.sv
// Round-robin picker over N_ENTRIES requests with a grant lock.
// Ports: clk_i, rst_ni, req_i, ready_i -> valid_o, id_o.
module hpdcache_rr_arbiter
  import hpdcache_pkg::*;
#(
  parameter int unsigned N_ENTRIES = WBUF_N_ENTRIES,
  parameter int unsigned ID_WIDTH = $clog2(N_ENTRIES)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [N_ENTRIES-1:0] req_i,
  input  logic                 ready_i,
  output logic                 valid_o,
  output logic [ID_WIDTH-1:0]  id_o
);

  logic [ID_WIDTH-1:0] ptr_q;
  logic [ID_WIDTH-1:0] lock_id_q;
  logic                lock_q;
  logic [ID_WIDTH-1:0] pick_id;
  logic [ID_WIDTH-1:0] idx;
  logic                pick_v;

  // Scan starting at the pointer; index wraps since
  // N_ENTRIES is a power of two.
  always_comb begin
    pick_v  = 1'b0;
    pick_id = '0;
    idx     = '0;
    for (int i = 0; i < N_ENTRIES; i++) begin
      idx = ptr_q + ID_WIDTH'(i);
      if (!pick_v && req_i[idx]) begin
        pick_v  = 1'b1;
        pick_id = idx;
      end
    end
  end

  assign valid_o = |req_i;

  // A stalled offer keeps its id until accepted.
  assign id_o = lock_q ? lock_id_q : pick_id;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q     <= '0;
      lock_q    <= 1'b0;
      lock_id_q <= '0;
    end else if (valid_o && ready_i) begin
      ptr_q  <= id_o + 1'b1;
      lock_q <= 1'b0;
    end else if (valid_o) begin
      lock_q    <= 1'b1;
      lock_id_q <= id_o;
    end else begin
      lock_q <= 1'b0;
    end
  end

endmodule

// File: rtl/hpdcache_wbuf_timer_ctrl.sv
// Write-buffer entry lifecycle: FREE->OPEN->PEND->SENT->FREE,
// closing OPEN entries on idle timeout or flush.
// Ports: alloc_*, write_*, threshold_i, flush_all_i,
// send_* (valid/ready), ack_*, empty_o, full_o,
// timeout_cnt_o (live only with HPDCACHE_WBUF_TIMER_PERF_EN).
module hpdcache_wbuf_timer_ctrl
  import hpdcache_pkg::*;
#(
  parameter int unsigned N_ENTRIES = WBUF_N_ENTRIES,
  parameter int unsigned TIMECNT_WIDTH =
    WBUF_TIMECNT_WIDTH,
  parameter int unsigned ID_WIDTH = $clog2(N_ENTRIES)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     alloc_i,
  output logic                     alloc_ready_o,
  output logic [ID_WIDTH-1:0]      alloc_id_o,
  input  logic                     write_i,
  input  logic [ID_WIDTH-1:0]      write_id_i,
  input  logic [TIMECNT_WIDTH-1:0] threshold_i,
  input  logic                     flush_all_i,
  output logic                     send_valid_o,
  output logic [ID_WIDTH-1:0]      send_id_o,
  input  logic                     send_ready_i,
  input  logic                     ack_i,
  input  logic [ID_WIDTH-1:0]      ack_id_i,
  output logic                     empty_o,
  output logic                     full_o,
  output logic [31:0]              timeout_cnt_o
);

  localparam logic [TIMECNT_WIDTH-1:0] CNT_MAX = '1;

  wbuf_state_e              st_q  [N_ENTRIES];
  wbuf_state_e              st_d  [N_ENTRIES];
  logic [TIMECNT_WIDTH-1:0] cnt_q [N_ENTRIES];
  logic [TIMECNT_WIDTH-1:0] cnt_d [N_ENTRIES];

  logic [N_ENTRIES-1:0] free_v;
  logic [N_ENTRIES-1:0] pend_v;
  logic [N_ENTRIES-1:0] to_hit;
  logic                 send_hs;

  always_comb begin
    free_v = '0;
    pend_v = '0;
    for (int i = 0; i < N_ENTRIES; i++) begin
      free_v[i] = (st_q[i] == WBUF_FREE);
      pend_v[i] = (st_q[i] == WBUF_PEND);
    end
  end

  // Descending scan so the lowest free index wins.
  always_comb begin
    alloc_id_o = '0;
    for (int i = N_ENTRIES - 1; i >= 0; i--) begin
      if (free_v[i]) alloc_id_o = ID_WIDTH'(i);
    end
  end

  assign alloc_ready_o = |free_v;
  assign empty_o       = &free_v;
  assign full_o        = ~|free_v;

  hpdcache_rr_arbiter #(
    .N_ENTRIES (N_ENTRIES),
    .ID_WIDTH  (ID_WIDTH)
  ) u_rr (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .req_i   (pend_v),
    .ready_i (send_ready_i),
    .valid_o (send_valid_o),
    .id_o    (send_id_o)
  );

  assign send_hs = send_valid_o & send_ready_i;

  always_comb begin
    logic wr_hit;
    logic hit_id;
    wr_hit = 1'b0;
    hit_id = 1'b0;
    to_hit = '0;
    for (int i = 0; i < N_ENTRIES; i++) begin
      st_d[i]  = st_q[i];
      cnt_d[i] = cnt_q[i];
      wr_hit   = write_i &&
                 (write_id_i == ID_WIDTH'(i));
      unique case (st_q[i])
        WBUF_FREE: begin
          hit_id = (alloc_id_o == ID_WIDTH'(i));
          if (alloc_i && alloc_ready_o && hit_id) begin
            st_d[i]  = WBUF_OPEN;
            cnt_d[i] = '0;
          end
        end
        WBUF_OPEN: begin
          // A write is always merged, even under flush.
          if (wr_hit) begin
            cnt_d[i] = '0;
          end else if (cnt_q[i] != CNT_MAX) begin
            cnt_d[i] = cnt_q[i] + 1'b1;
          end
          if (flush_all_i) begin
            st_d[i] = WBUF_PEND;
          end else if (!wr_hit &&
                       cnt_q[i] >= threshold_i) begin
            st_d[i]   = WBUF_PEND;
            to_hit[i] = 1'b1;
          end
        end
        WBUF_PEND: begin
          hit_id = (send_id_o == ID_WIDTH'(i));
          if (send_hs && hit_id) st_d[i] = WBUF_SENT;
        end
        WBUF_SENT: begin
          hit_id = (ack_id_i == ID_WIDTH'(i));
          if (ack_i && hit_id) st_d[i] = WBUF_FREE;
        end
        default: st_d[i] = WBUF_FREE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < N_ENTRIES; i++) begin
        st_q[i]  <= WBUF_FREE;
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_ENTRIES; i++) begin
        st_q[i]  <= st_d[i];
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

`ifdef HPDCACHE_WBUF_TIMER_PERF_EN
  logic [31:0] tcnt_q;
  logic [31:0] tcnt_d;

  // Only idle-timeout closures count, flushes do not.
  always_comb begin
    tcnt_d = tcnt_q;
    for (int i = 0; i < N_ENTRIES; i++) begin
      tcnt_d = tcnt_d + 32'(to_hit[i]);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) tcnt_q <= '0;
    else         tcnt_q <= tcnt_d;
  end

  assign timeout_cnt_o = tcnt_q;
`else
  logic perf_unused;
  assign perf_unused   = |to_hit;
  assign timeout_cnt_o = '0;
`endif

endmodule
